// File: rtl/kbd_matrix_ctrl.sv
// kbd_matrix_ctrl: PS/2 to key-matrix controller with a loadable keymap and a timed key-injection queue.
module kbd_matrix_ctrl #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int HOLD_CYC   = 50000,
    parameter int GAP_CYC    = 50000,
    parameter int SHIFT_ROW  = 7,
    parameter int SHIFT_COL  = 6
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [10:0]     ps2_key,
    input  logic            kbd_clear,
    input  logic            map_we,
    input  logic [8:0]      map_addr,
    input  logic [7:0]      map_wdata,
    input  logic            inj_valid,
    input  logic [7:0]      inj_data,
    output logic            inj_ready,
    output logic            inj_busy,
    input  logic [COLS-1:0] col_sel,
    output logic [ROWS-1:0] rows_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2((HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC) + 1);

    typedef enum logic [1:0] {IDLE, LOAD, PRESS, GAP} state_t;

    logic [7:0]                map_ram [512];
    logic [7:0]                map_q;
    logic                      tog_q, ev_v, ev_pressed, push, pop, shift_on;
    logic [ROWS-1:0][COLS-1:0] live, inj, ev_mask, shift_mask, eff;
    logic [3:0]                shift_cnt;
    logic [7:0]                fifo [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [AW:0]               cnt, cnt_nx;
    logic [7:0]                cur;
    logic [TW-1:0]             timer;
    state_t                    state;

    // One-hot key position; invalid or out-of-range entries yield an empty mask.
    function automatic logic [ROWS-1:0][COLS-1:0] key_mask(input logic [7:0] d);
        key_mask = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                key_mask[r][c] = d[7] && int'(d[5:3]) == r && int'(d[2:0]) == c;
    endfunction

    assign ev_mask    = key_mask(map_q);
    assign shift_mask = key_mask({2'b10, 3'(SHIFT_ROW), 3'(SHIFT_COL)});
    assign push       = inj_valid && inj_ready;
    assign pop        = state == IDLE && cnt != 0;
    assign cnt_nx     = cnt + (AW+1)'(push) - (AW+1)'(pop);
    assign inj_busy   = cnt != 0 || state != IDLE;
    assign shift_on   = shift_cnt != 0 || live[SHIFT_ROW][SHIFT_COL];

    always_ff @(posedge clk_sys) begin
        if (map_we) map_ram[map_addr] <= map_wdata;
        map_q <= map_ram[ps2_key[8:0]];
    end

    always_ff @(posedge clk_sys)
        if (push) fifo[wr_ptr] <= inj_data;

    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            tog_q      <= 1'b0;
            ev_v       <= 1'b0;
            ev_pressed <= 1'b0;
            live       <= '0;
            shift_cnt  <= '0;
        end else begin
            tog_q      <= ps2_key[10];
            ev_v       <= ps2_key[10] != tog_q;
            ev_pressed <= ps2_key[9];
            if (kbd_clear) begin
                live      <= '0;
                shift_cnt <= '0;
            end else if (ev_v && |ev_mask) begin
                live <= ev_pressed ? live | ev_mask : live & ~ev_mask;
                if (map_q[6])
                    shift_cnt <= ev_pressed ? shift_cnt + {3'b0, shift_cnt != 4'hF}
                                            : shift_cnt - {3'b0, shift_cnt != 4'h0};
            end
        end

    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            inj_ready <= 1'b1;
            state     <= IDLE;
            timer     <= '0;
            inj       <= '0;
            cur       <= '0;
        end else begin
            cnt       <= cnt_nx;
            inj_ready <= cnt_nx != (AW+1)'(FIFO_DEPTH);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            case (state)
                IDLE:
                    if (pop) begin
                        cur    <= fifo[rd_ptr];
                        rd_ptr <= rd_ptr + AW'(1);
                        state  <= LOAD;
                    end
                LOAD:
                    if (|key_mask(cur)) begin
                        inj   <= key_mask(cur) | (cur[6] ? shift_mask : '0);
                        timer <= TW'(HOLD_CYC - 1);
                        state <= PRESS;
                    end else
                        state <= IDLE;
                PRESS:
                    if (timer == 0) begin
                        inj   <= '0;
                        timer <= TW'(GAP_CYC - 1);
                        state <= GAP;
                    end else
                        timer <= timer - TW'(1);
                GAP:
                    if (timer == 0) state <= IDLE;
                    else timer <= timer - TW'(1);
                default: state <= IDLE;
            endcase
        end

    always_comb begin
        eff = live | inj | (shift_on ? shift_mask : '0);
        for (int r = 0; r < ROWS; r++)
            rows_out[r] = ~|(~col_sel & eff[r]);
    end
endmodule

// File: tb/tb_kbd_matrix_ctrl.sv
// tb_kbd_matrix_ctrl: random and directed stimulus checked against an event-level model of the keyboard controller.
module tb_kbd_matrix_ctrl;
    localparam int DEPTH = 4, HOLD = 5, GAP = 3;

    logic        clk_sys = 1'b0, reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic        kbd_clear = 1'b0, map_we = 1'b0, inj_valid = 1'b0;
    logic [8:0]  map_addr = '0;
    logic [7:0]  map_wdata = '0, inj_data = '0, col_sel = 8'hFF;
    logic        inj_ready, inj_busy;
    logic [7:0]  rows_out;
    int          tests = 0, fails = 0;

    kbd_matrix_ctrl #(.ROWS(8), .COLS(8), .FIFO_DEPTH(DEPTH), .HOLD_CYC(HOLD), .GAP_CYC(GAP),
                      .SHIFT_ROW(7), .SHIFT_COL(6)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .kbd_clear(kbd_clear),
        .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
        .inj_valid(inj_valid), .inj_data(inj_data), .inj_ready(inj_ready), .inj_busy(inj_busy),
        .col_sel(col_sel), .rows_out(rows_out));

    always #5 clk_sys = ~clk_sys;

    // Model: live keys as a 64-bit set (bit r*8+c), shift as a plain count, injector as time windows.
    logic [7:0]  map_m [512];
    logic [63:0] live_m, cur_m;
    logic [7:0]  p1_d, q[$];
    logic        p1_v, p1_pr, tog;
    int          scnt, now, busy_until, lo, hi;

    function automatic logic [63:0] mask_of(input logic [7:0] d);
        return d[7] ? 64'd1 << (int'(d[5:3]) * 8 + int'(d[2:0])) : 64'd0;
    endfunction

    function automatic logic [7:0] exp_rows();
        logic [63:0] eff;
        logic [7:0]  res;
        eff = live_m | ((now >= lo && now <= hi) ? cur_m : 64'd0);
        if (scnt != 0 || live_m[62]) eff[62] = 1'b1;
        res = 8'hFF;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (!col_sel[c] && eff[r*8+c]) res[r] = 1'b0;
        return res;
    endfunction

    task automatic model_reset();
        live_m = '0; cur_m = '0; scnt = 0; now = 0; busy_until = 0; lo = 1; hi = 0;
        p1_v = 1'b0; p1_pr = 1'b0; p1_d = '0; tog = 1'b0; q.delete();
    endtask

    task automatic model_step();
        logic [63:0] m;
        logic [7:0]  d;
        logic        rdy;
        now++;
        if (kbd_clear) begin
            live_m = '0; scnt = 0;
        end else if (p1_v && p1_d[7]) begin
            m = mask_of(p1_d);
            live_m = p1_pr ? (live_m | m) : (live_m & ~m);
            if (p1_d[6]) scnt = p1_pr ? ((scnt < 15) ? scnt + 1 : 15) : ((scnt > 0) ? scnt - 1 : 0);
        end
        p1_v  = ps2_key[10] != tog;
        tog   = ps2_key[10];
        p1_pr = ps2_key[9];
        p1_d  = map_m[ps2_key[8:0]];
        if (map_we) map_m[map_addr] = map_wdata;
        rdy = q.size() < DEPTH;
        if (now - 1 >= busy_until && q.size() > 0) begin
            d = q.pop_front();
            cur_m = mask_of(d) | (d[6] ? 64'd1 << 62 : 64'd0);
            lo = now + 1;
            hi = d[7] ? now + HOLD : now;
            busy_until = d[7] ? now + 1 + HOLD + GAP : now + 1;
        end
        if (inj_valid && rdy) q.push_back(inj_data);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    task automatic ev(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
        tick();
    endtask

    task automatic mapw(input logic [8:0] a, input logic [7:0] d);
        map_we = 1'b1; map_addr = a; map_wdata = d;
        tick();
        map_we = 1'b0;
    endtask

    task automatic clear_keys();
        kbd_clear = 1'b1;
        tick();
        kbd_clear = 1'b0;
    endtask

    always @(negedge clk_sys) begin
        check("rows_out", 32'(rows_out), 32'(exp_rows()));
        check("inj_ready", 32'(inj_ready), 32'(q.size() < DEPTH));
        check("inj_busy", 32'(inj_busy), 32'(q.size() != 0 || now < busy_until));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ent [3];
        logic [7:0] prev;
        logic [8:0] code;
        int n, low, presses;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        for (int a = 0; a < 512; a++) mapw(9'(a), 8'($urandom));

        // Basic press/release with two-clock latency
        mapw(9'h01C, 8'h81);
        clear_keys();
        col_sel = 8'hFD;
        ev(1'b1, 9'h01C);
        check("t1_latency1", 32'(rows_out), 32'hFF);
        tick();
        check("t1_press", 32'(rows_out), 32'hFE);
        ev(1'b0, 9'h01C);
        tick();
        check("t1_release", 32'(rows_out), 32'hFF);

        // Shift mapped key and physical shift
        mapw(9'h052, 8'hE7);
        mapw(9'h012, 8'hBE);
        clear_keys();
        col_sel = 8'h00;
        ev(1'b1, 9'h052); tick();
        check("t2_shift_key", 32'(rows_out), 32'h6F);
        ev(1'b1, 9'h012); tick();
        check("t2_both", 32'(rows_out), 32'h6F);
        ev(1'b0, 9'h052); tick();
        check("t2_phys_shift", 32'(rows_out), 32'h7F);
        ev(1'b0, 9'h012); tick();
        check("t2_all_up", 32'(rows_out), 32'hFF);

        // Shift count saturates at 15 and floors at 0
        col_sel = 8'hBF;
        repeat (16) ev(1'b1, 9'h052);
        tick();
        repeat (14) ev(1'b0, 9'h052);
        tick();
        check("t2_sat_14", 32'(rows_out), 32'h7F);
        ev(1'b0, 9'h052); tick();
        check("t2_sat_15", 32'(rows_out), 32'hFF);
        ev(1'b0, 9'h052); tick();
        check("t2_floor", 32'(rows_out), 32'hFF);
        ev(1'b1, 9'h052); tick();
        check("t2_after_floor", 32'(rows_out), 32'h7F);
        ev(1'b0, 9'h052); tick();

        // Map write coinciding with lookup returns old data
        clear_keys();
        col_sel = 8'h00;
        map_we = 1'b1; map_addr = 9'h01C; map_wdata = 8'h93;
        ps2_key = {~ps2_key[10], 1'b1, 9'h01C};
        tick();
        map_we = 1'b0;
        tick();
        check("t6_old_map", 32'(rows_out), 32'hFE);
        ev(1'b0, 9'h01C); tick();
        check("t6_new_release", 32'(rows_out), 32'hFE);
        ev(1'b1, 9'h01C); tick();
        check("t6_new_press", 32'(rows_out), 32'hFA);
        clear_keys();
        check("t6_clear", 32'(rows_out), 32'hFF);
        mapw(9'h01C, 8'h81);

        // Three injected keys replayed in order
        ent = '{8'h8A, 8'hD3, 8'h9C};
        n = 0; low = 0;
        for (int i = 0; i < 3; i++) begin
            inj_valid = 1'b1; inj_data = ent[i];
            tick();
            n++; low += int'(rows_out != 8'hFF);
        end
        inj_valid = 1'b0;
        while (inj_busy && n < 200) begin
            tick();
            n++; low += int'(rows_out != 8'hFF);
        end
        check("t3_busy_len", 32'(n), 32'(1 + 3 * (HOLD + GAP + 2)));
        check("t3_low_cycles", 32'(low), 32'(3 * HOLD));

        // Queue overflow while the injector is busy
        inj_valid = 1'b1; inj_data = 8'h8A;
        tick();
        inj_valid = 1'b0;
        n = 0;
        while (rows_out == 8'hFF && n < 50) begin tick(); n++; end
        check("t4_first_press", 32'(rows_out != 8'hFF), 32'd1);
        for (int i = 0; i < DEPTH + 2; i++) begin
            inj_valid = 1'b1; inj_data = 8'(8'h80 + i * 9);
            tick();
            if (i == DEPTH - 1) check("t4_full", 32'(inj_ready), 32'd0);
        end
        inj_valid = 1'b0;
        check("t4_still_full", 32'(inj_ready), 32'd0);
        prev = rows_out; presses = 0; n = 0;
        while (inj_busy && n < 300) begin
            tick();
            n++;
            if (prev == 8'hFF && rows_out != 8'hFF) presses++;
            prev = rows_out;
        end
        check("t4_replayed", 32'(presses), 32'(DEPTH));

        // Reset during a press aborts at once and keeps the keymap
        inj_valid = 1'b1; inj_data = 8'h8A; tick();
        inj_data = 8'h89; tick();
        inj_valid = 1'b0;
        n = 0;
        while (rows_out == 8'hFF && n < 50) begin tick(); n++; end
        check("t5_pressing", 32'(rows_out != 8'hFF), 32'd1);
        reset = 1'b1;
        model_reset();
        #1;
        check("t5_rows", 32'(rows_out), 32'hFF);
        check("t5_busy", 32'(inj_busy), 32'd0);
        check("t5_ready", 32'(inj_ready), 32'd1);
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        clear_keys();
        col_sel = 8'hFD;
        ev(1'b1, 9'h01C); tick();
        check("t5_map_kept", 32'(rows_out), 32'hFE);
        ev(1'b0, 9'h01C); tick();

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            col_sel = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            case ($urandom_range(4))
                0: code = 9'h01C;
                1: code = 9'h052;
                2: code = 9'h012;
                3: code = 9'h11C;
                default: code = 9'($urandom);
            endcase
            if ($urandom_range(3) == 0) ps2_key = {~ps2_key[10], 1'($urandom), code};
            map_we    = $urandom_range(19) == 0;
            map_addr  = ($urandom_range(1) == 0) ? code : 9'($urandom);
            map_wdata = 8'($urandom);
            kbd_clear = $urandom_range(49) == 0;
            inj_valid = $urandom_range(7) == 0;
            inj_data  = 8'($urandom);
            if ($urandom_range(999) == 0) begin
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end
            tick();
        end
        map_we = 1'b0; kbd_clear = 1'b0; inj_valid = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
